// File: rtl/clz_norm_pipe.sv
// Pipelined leading-zero counter and left normaliser with valid/ready flow control.
// Optional signed (redundant sign bit) counting is enabled by defining CLZ_NORM_SIGNED_EN.
module clz_norm_pipe #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned REG_EVERY = 1,
  parameter int unsigned TAG_W     = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_in_valid,
  output logic                   io_in_ready,
  input  logic [WIDTH-1:0]       io_in_bits,
  input  logic [TAG_W-1:0]       io_in_tag,
`ifdef CLZ_NORM_SIGNED_EN
  input  logic                   io_in_signed,
`endif
  output logic                   io_out_valid,
  input  logic                   io_out_ready,
  output logic [$clog2(WIDTH):0] io_out_count,
  output logic [WIDTH-1:0]       io_out_norm,
  output logic                   io_out_zero,
  output logic [TAG_W-1:0]       io_out_tag
);

  localparam int unsigned L  = $clog2(WIDTH);
  localparam int unsigned CW = L + 1;
  localparam int unsigned S  = (L + REG_EVERY - 1) / REG_EVERY;
  localparam logic [WIDTH-1:0] ONES = '1;

  logic                    init_q;
  logic [S-1:0]            vld_q, vld_d, ld;
  logic [S-1:0][WIDTH-1:0] work_q, work_d;
  logic [S-1:0][CW-1:0]    cnt_q, cnt_d;
  logic [S-1:0][TAG_W-1:0] tag_q, tag_d;
  logic                    zero_q, zero_d;
  logic [WIDTH-1:0]        in_search;

  // Stage s reads element s of each chain; element S is the output register.
  logic [S:0]              chain_v;
  logic [S:0][WIDTH-1:0]   chain_w;
  logic [S:0][CW-1:0]      chain_c;
  logic [S:0][TAG_W-1:0]   chain_t;

`ifdef CLZ_NORM_SIGNED_EN
  logic [S-1:0][WIDTH-1:0] dat_q, dat_d;
  logic [S-1:0]            sgn_q, sgn_d;
  logic [S:0][WIDTH-1:0]   chain_d;
  logic [S:0]              chain_s;

  // Signed search value: sign-XORed bits [WIDTH-2:0] moved to the top, so the
  // count of the search value equals the redundant-sign-bit count.
  assign in_search = io_in_signed ?
                     {io_in_bits[WIDTH-2:0] ^ {(WIDTH-1){io_in_bits[WIDTH-1]}}, 1'b0} :
                     io_in_bits;
  assign chain_d   = {dat_q, io_in_bits};
  assign chain_s   = {sgn_q, io_in_signed};
`else
  assign in_search = io_in_bits;
`endif

  assign chain_v = {vld_q, io_in_valid && init_q};
  assign chain_w = {work_q, in_search};
  assign chain_c = {cnt_q, {CW{1'b0}}};
  assign chain_t = {tag_q, io_in_tag};

  // Stage loads when any stage at or after it is empty, or the consumer drains.
  always_comb begin
    logic full;
    full = 1'b1;
    ld   = '0;
    for (int unsigned i = 0; i < S; i++) begin
      full          = full && vld_q[S-1-i];
      ld[S-1-i]     = io_out_ready || !full;
    end
  end

  assign io_in_ready = init_q && ld[0];

  always_comb begin
    logic [WIDTH-1:0] w;
    logic [CW-1:0]    c;
    int unsigned      lv;
`ifdef CLZ_NORM_SIGNED_EN
    logic [WIDTH-1:0] d;
    d     = '0;
    dat_d = '0;
    sgn_d = chain_s[S-1:0];
`endif
    w      = '0;
    c      = '0;
    lv     = 0;
    vld_d  = chain_v[S-1:0];
    tag_d  = chain_t[S-1:0];
    work_d = '0;
    cnt_d  = '0;
    zero_d = 1'b0;
    for (int unsigned s = 0; s < S; s++) begin
      w = chain_w[s];
      c = chain_c[s];
`ifdef CLZ_NORM_SIGNED_EN
      d = chain_d[s];
`endif
      for (int unsigned j = 0; j < REG_EVERY; j++) begin
        if (s * REG_EVERY + j < L) begin
          lv = L - 1 - (s * REG_EVERY + j);
          if ((w & ~(ONES >> (1 << lv))) == '0) begin
            w = w << (1 << lv);
            c = c | (CW'(1) << lv);
`ifdef CLZ_NORM_SIGNED_EN
            d = d << (1 << lv);
`endif
          end
        end
      end
      work_d[s] = w;
      cnt_d[s]  = c;
`ifdef CLZ_NORM_SIGNED_EN
      dat_d[s]  = d;
`endif
    end
    // An all-zero search value has taken every shift (count WIDTH-1); unsigned
    // operands report WIDTH, signed ones saturate at WIDTH-1 as already counted.
    zero_d = (work_d[S-1] == '0);
`ifdef CLZ_NORM_SIGNED_EN
    if (zero_d && !sgn_d[S-1]) cnt_d[S-1] = CW'(WIDTH);
`else
    if (zero_d) cnt_d[S-1] = CW'(WIDTH);
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      init_q <= 1'b0;
      vld_q  <= '0;
      work_q <= '0;
      cnt_q  <= '0;
      tag_q  <= '0;
      zero_q <= 1'b0;
`ifdef CLZ_NORM_SIGNED_EN
      dat_q  <= '0;
      sgn_q  <= '0;
`endif
    end else begin
      init_q <= 1'b1;
      for (int unsigned s = 0; s < S; s++) begin
        if (ld[s]) begin
          vld_q[s]  <= vld_d[s];
          work_q[s] <= work_d[s];
          cnt_q[s]  <= cnt_d[s];
          tag_q[s]  <= tag_d[s];
`ifdef CLZ_NORM_SIGNED_EN
          dat_q[s]  <= dat_d[s];
          sgn_q[s]  <= sgn_d[s];
`endif
        end
      end
      if (ld[S-1]) zero_q <= zero_d;
    end
  end

  assign io_out_valid = chain_v[S];
  assign io_out_count = chain_c[S];
  assign io_out_zero  = zero_q;
  assign io_out_tag   = chain_t[S];
`ifdef CLZ_NORM_SIGNED_EN
  assign io_out_norm  = chain_d[S];
`else
  assign io_out_norm  = chain_w[S];
`endif

endmodule
